// File: rtl/dmem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl_if
// Word-addressed req/ack data bus between the MEM-stage access sequencer
// (master) and the data memory (slave).
//   bus_req   : master -> slave, transaction request
//   bus_we    : master -> slave, write strobe
//   bus_addr  : master -> slave, word-aligned byte address (bits[1:0] = 00)
//   bus_be    : master -> slave, byte enables
//   bus_wdata : master -> slave, byte-lane-aligned write data
//   bus_rdata : slave -> master, read data, valid with bus_ack
//   bus_ack   : slave -> master, transaction accepted/completed
// ---------------------------------------------------------------------------
interface dmem_access_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
// MEM-stage data-memory access sequencer for the RV32I pipeline. Turns the
// decoded load/store controls into one or two word-bus transactions, merges
// and extends load data, and stalls the pipeline until the access completes.
// Ports:
//   clk, reset      : core clock, synchronous active-high reset
//   req_*           : MEM-stage request, held stable while stall = 1
//   stall           : hold IF..MEM (combinational on req_valid)
//   done / err      : one-cycle completion pulse / timeout flag (with done)
//   rdata           : extended load result, valid with done
//   bus             : master side of the word-addressed req/ack data bus
// ---------------------------------------------------------------------------
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16  // max wait cycles per transaction, 2..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_lwhb,
  input  logic [1:0]  req_swhb,
  input  logic        req_lunsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  dmem_access_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACC1 = 3'd1;
  localparam logic [2:0] S_ACC2 = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  // The timer counts completed wait cycles; the cycle in which it would
  // reach TIMEOUT is the last one the bus gets.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  state, state_nxt;
  logic [7:0]  timer;
  logic [31:0] merge_buf, merge_nxt;

  // Request fields captured on leaving IDLE.
  logic        lat_write, lat_uns;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr, lat_wdata;

  // Effective request: live inputs while IDLE, latched copy afterwards.
  logic        f_write, f_uns;
  logic [1:0]  f_size;
  logic [31:0] f_addr, f_wdata;

  logic [1:0]  k;
  logic [5:0]  sh;          // 8*k, byte-lane shift in bits
  logic        split, ack, in_acc, go_acc;
  logic [31:0] word_addr, hi_mask, load_ext, wdata_first, wdata_second;
  logic [3:0]  be_first, be_second;

  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path through the block can leave a latch behind.
    f_write = lat_write;
    f_size  = lat_size;
    f_uns   = lat_uns;
    f_addr  = lat_addr;
    f_wdata = lat_wdata;
    if (state == S_IDLE) begin
      f_write = req_write;
      f_size  = req_write ? req_swhb : req_lwhb;
      f_uns   = req_lunsigned;
      f_addr  = req_addr;
      f_wdata = req_wdata;
    end
  end

  assign k         = f_addr[1:0];
  assign sh        = {1'b0, k, 3'b000};
  assign word_addr = {f_addr[31:2], 2'b00};
  assign split     = (f_size == SZ_HALF && k == 2'd3) || (f_size == SZ_WORD && k != 2'd0);
  assign in_acc    = (state == S_ACC1) || (state == S_ACC2);
  assign ack       = bus.bus_req && bus.bus_ack;
  assign stall     = req_valid && !((state == S_DONE) || (state == S_ERR));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid) state_nxt = (f_size == 2'b00) ? S_DONE : S_ACC1;
      S_ACC1: begin
        if (ack)                       state_nxt = split ? S_ACC2 : S_DONE;
        else if (timer == TIMER_LAST)  state_nxt = S_ERR;
      end
      S_ACC2: begin
        if (ack)                       state_nxt = S_DONE;
        else if (timer == TIMER_LAST)  state_nxt = S_ERR;
      end
      S_DONE, S_ERR: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign go_acc = (state_nxt == S_ACC1) || (state_nxt == S_ACC2);

  // Lane steering: the first transaction shifts data up into lane k, the
  // second carries the bytes that spilled past lane 3 into the next word.
  always_comb begin
    be_first  = 4'b0000;
    be_second = 4'b0000;
    case (f_size)
      SZ_BYTE: be_first = 4'b0001 << k;
      SZ_HALF: begin
        be_first  = 4'b0011 << k;
        be_second = 4'b0001;
      end
      SZ_WORD: begin
        be_first  = 4'b1111 << k;
        be_second = 4'b1111 >> (3'd4 - {1'b0, k});
      end
      default: ;
    endcase
  end

  assign wdata_first  = f_wdata << sh;
  assign wdata_second = f_wdata >> (6'd32 - sh);

  // Load merge: first beat lands shifted down to bit 0, second beat fills the
  // top 8*k bits from its low lanes.
  always_comb begin
    hi_mask   = ~(32'hFFFF_FFFF >> sh);
    merge_nxt = merge_buf;
    if (ack && state == S_ACC1)
      merge_nxt = bus.bus_rdata >> sh;
    else if (ack && state == S_ACC2)
      merge_nxt = (merge_buf & ~hi_mask) | ((bus.bus_rdata << (6'd32 - sh)) & hi_mask);
  end

  always_comb begin
    load_ext = 32'd0;
    case (f_size)
      SZ_BYTE: load_ext = {{24{~f_uns & merge_nxt[7]}},  merge_nxt[7:0]};
      SZ_HALF: load_ext = {{16{~f_uns & merge_nxt[15]}}, merge_nxt[15:0]};
      SZ_WORD: load_ext = merge_nxt;
      default: load_ext = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      timer         <= 8'd0;
      merge_buf     <= 32'd0;
      lat_write     <= 1'b0;
      lat_uns       <= 1'b0;
      lat_size      <= 2'b00;
      lat_addr      <= 32'd0;
      lat_wdata     <= 32'd0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'd0;
      bus.bus_be    <= 4'b0000;
      bus.bus_wdata <= 32'd0;
      done          <= 1'b0;
      err           <= 1'b0;
      rdata         <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments throughout: every register here sees
      // the pre-edge values of the others, which is what the FSM relies on.
      state     <= state_nxt;
      timer     <= (in_acc && !ack) ? timer + 8'd1 : 8'd0;
      merge_buf <= merge_nxt;
      if (state == S_IDLE) begin
        lat_write <= f_write;
        lat_uns   <= f_uns;
        lat_size  <= f_size;
        lat_addr  <= f_addr;
        lat_wdata <= f_wdata;
      end
      bus.bus_req   <= go_acc;
      bus.bus_we    <= go_acc && f_write;
      bus.bus_addr  <= !go_acc ? 32'd0 :
                       (state_nxt == S_ACC2) ? word_addr + 32'd4 : word_addr;
      bus.bus_be    <= (state_nxt == S_ACC1) ? be_first :
                       (state_nxt == S_ACC2) ? be_second : 4'b0000;
      bus.bus_wdata <= (state_nxt == S_ACC1) ? wdata_first :
                       (state_nxt == S_ACC2) ? wdata_second : 32'd0;
      done  <= (state_nxt == S_DONE) || (state_nxt == S_ERR);
      err   <= (state_nxt == S_ERR);
      rdata <= (state_nxt == S_DONE && !f_write) ? load_ext : 32'd0;
    end
  end

endmodule
